// File: rtl/axi_slave_push_fsm.sv
// Completion push engine: turns P2A completions into AXI B responses and segmented R beats.
// Optional feature: define AXI_SLAVE_PUSH_ERR_CNT_EN to add the saturating Err_Count output.
package axi_slave_package;
    typedef enum logic [1:0] {
        NO_CPL    = 2'd0,
        CPL_B     = 2'd1,
        CPL_R     = 2'd2,
        CPL_R_ERR = 2'd3
    } cpl_t;
endpackage

module axi_slave_push_fsm
    import axi_slave_package::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int BEAT_WIDTH = 256,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  cpl_t                  Cpl_Type,
    input  logic [9:0]            Cpl_Length,
    input  logic [DATA_WIDTH-1:0] Cpl_Data,
    input  logic [ID_WIDTH-1:0]   Cpl_ID,
    output logic                  Cpl_Grant,
    output logic                  Cpl_Command,
    output logic                  B_Push,
    output logic [ID_WIDTH-1:0]   B_ID,
    output logic [1:0]            B_Resp,
    input  logic                  B_Full,
    output logic                  R_Push,
    output logic [BEAT_WIDTH-1:0] R_Data,
    output logic [ID_WIDTH-1:0]   R_ID,
    output logic [1:0]            R_Resp,
    output logic                  R_Last,
    input  logic                  R_Full
`ifdef AXI_SLAVE_PUSH_ERR_CNT_EN
    ,
    output logic [15:0]           Err_Count
`endif
);
    localparam int SEGS  = DATA_WIDTH / BEAT_WIDTH;
    localparam int DWPB  = BEAT_WIDTH / 32;
    localparam int SEG_W = (SEGS > 1) ? $clog2(SEGS) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_R_PUSH = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [0:0]          r_state;
    logic [10:0]         r_beats_left;
    logic [SEG_W-1:0]    r_seg;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_err;

    logic        w_in_r;
    logic        w_last;
    logic        w_seg_end;
    logic        w_hdr_r;
    logic        w_r_push;
    logic [10:0] w_len;
    logic [10:0] w_beats_init;

    assign w_in_r       = (r_state == S_R_PUSH);
    assign w_len        = (Cpl_Length == 10'd0) ? 11'd1024 : {1'b0, Cpl_Length};
    assign w_beats_init = 11'(({1'b0, w_len} + 12'(DWPB - 1)) / 12'(DWPB));
    assign w_last       = (r_beats_left == 11'd1);
    assign w_seg_end    = (r_seg == SEG_W'(SEGS - 1));
    assign w_hdr_r      = ARESETn && !w_in_r && (Cpl_Type == CPL_R || Cpl_Type == CPL_R_ERR);
    // Error bursts carry no P2A data, so they push regardless of the data-valid type.
    assign w_r_push     = ARESETn && w_in_r && !R_Full && (r_err || Cpl_Type != NO_CPL);
    assign Cpl_Command  = w_in_r;

    always_comb begin
        Cpl_Grant = 1'b0;
        B_Push    = 1'b0;
        B_ID      = '0;
        B_Resp    = RESP_OKAY;
        R_Push    = w_r_push;
        R_Data    = '0;
        R_ID      = '0;
        R_Resp    = RESP_OKAY;
        R_Last    = 1'b0;
        if (ARESETn) begin
            if (w_in_r) begin
                R_ID      = r_id;
                R_Resp    = r_err ? RESP_SLVERR : RESP_OKAY;
                R_Last    = w_last;
                if (!r_err) begin
                    R_Data = Cpl_Data[r_seg*BEAT_WIDTH +: BEAT_WIDTH];
                end
                // A chunk is released once its last segment (or the burst's last beat) goes out.
                Cpl_Grant = w_r_push && !r_err && (w_seg_end || w_last);
            end else if (Cpl_Type == CPL_B) begin
                B_ID      = Cpl_ID;
                B_Push    = !B_Full;
                Cpl_Grant = !B_Full;
            end else begin
                Cpl_Grant = w_hdr_r;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state      <= S_IDLE;
            r_beats_left <= '0;
            r_seg        <= '0;
            r_err        <= 1'b0;
        end else if (w_hdr_r) begin
            r_state      <= S_R_PUSH;
            r_beats_left <= w_beats_init;
            r_seg        <= '0;
            r_err        <= (Cpl_Type == CPL_R_ERR);
        end else if (w_r_push) begin
            r_beats_left <= r_beats_left - 11'd1;
            r_seg        <= w_seg_end ? '0 : r_seg + SEG_W'(1);
            if (w_last) begin
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_hdr_r) begin
            r_id <= Cpl_ID;
        end
    end

`ifdef AXI_SLAVE_PUSH_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_err_cnt <= '0;
        end else if (w_hdr_r && Cpl_Type == CPL_R_ERR && r_err_cnt != 16'hFFFF) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign Err_Count = r_err_cnt;
`endif
endmodule

// File: tb/tb_axi_slave_push_fsm.sv
// Bench for axi_slave_push_fsm: acts as P2A and the B/R buffers, checks every push against a DW-level model.
module tb_axi_slave_push_fsm;
    import axi_slave_package::*;

    logic          ACLK;
    logic          ARESETn;
    cpl_t          Cpl_Type;
    logic [9:0]    Cpl_Length;
    logic [1023:0] Cpl_Data;
    logic [3:0]    Cpl_ID;
    logic          Cpl_Grant;
    logic          Cpl_Command;
    logic          B_Push;
    logic [3:0]    B_ID;
    logic [1:0]    B_Resp;
    logic          B_Full;
    logic          R_Push;
    logic [255:0]  R_Data;
    logic [3:0]    R_ID;
    logic [1:0]    R_Resp;
    logic          R_Last;
    logic          R_Full;
`ifdef AXI_SLAVE_PUSH_ERR_CNT_EN
    logic [15:0]   Err_Count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   id;
        logic [1:0]   resp;
        logic         last;
    } rbeat_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bresp_t;

    rbeat_t rq[$];
    bresp_t bq[$];
    rbeat_t mon_r;
    bresp_t mon_b;
    logic [31:0] last_lo;

    axi_slave_push_fsm dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .Cpl_Type    (Cpl_Type),
        .Cpl_Length  (Cpl_Length),
        .Cpl_Data    (Cpl_Data),
        .Cpl_ID      (Cpl_ID),
        .Cpl_Grant   (Cpl_Grant),
        .Cpl_Command (Cpl_Command),
        .B_Push      (B_Push),
        .B_ID        (B_ID),
        .B_Resp      (B_Resp),
        .B_Full      (B_Full),
        .R_Push      (R_Push),
        .R_Data      (R_Data),
        .R_ID        (R_ID),
        .R_Resp      (R_Resp),
        .R_Last      (R_Last),
        .R_Full      (R_Full)
`ifdef AXI_SLAVE_PUSH_ERR_CNT_EN
        ,
        .Err_Count   (Err_Count)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // DW i of the payload stream for transaction 'tag'.
    function automatic logic [31:0] dw(input int tag, input int i);
        return {8'hD0 ^ 8'(tag), 8'(tag), 16'(i)};
    endfunction

    function automatic logic [1023:0] chunk(input int tag, input int c);
        logic [1023:0] v;
        for (int k = 0; k < 32; k++) v[k*32 +: 32] = dw(tag, c*32 + k);
        return v;
    endfunction

    // Expected R beats: beat b carries payload DWs 8b..8b+7; error bursts carry zeros.
    task automatic model_r(input logic err, input logic [3:0] id, input logic [9:0] len, input int tag);
        int l;
        int n;
        rbeat_t e;
        l = (len == 10'd0) ? 1024 : int'(len);
        n = (l + 7) / 8;
        for (int b = 0; b < n; b++) begin
            e.data = '0;
            if (!err) for (int k = 0; k < 8; k++) e.data[k*32 +: 32] = dw(tag, 8*b + k);
            e.id   = id;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = (b == n - 1);
            rq.push_back(e);
        end
    endtask

    always @(negedge ACLK) begin
        if (ARESETn && R_Push) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 272'(R_Push), 272'(0));
            end else begin
                mon_r = rq.pop_front();
                check("r_beat", 272'({R_Data, R_ID, R_Resp, R_Last}), 272'(mon_r));
            end
        end
        if (ARESETn && B_Push) begin
            check("b_not_in_burst", 272'(Cpl_Command), 272'(0));
            if (bq.size() == 0) begin
                check("b_unexpected", 272'(B_Push), 272'(0));
            end else begin
                mon_b = bq.pop_front();
                check("b_resp", 272'({B_ID, B_Resp}), 272'(mon_b));
            end
        end
    end

    // Plays P2A for one read completion; called right after a rising edge.
    task automatic run_r(input logic err, input logic [3:0] id, input logic [9:0] len, input int tag,
                         input logic [63:0] stall, input logic [63:0] gap, input int exp_beats,
                         input int exp_grants, input int exp_cmd, input int rst_after,
                         output logic [31:0] lo);
        int cyc;
        int c;
        int g;
        int beats;
        int first;
        int cmd_cnt;
        logic done;
        logic aborted;
        model_r(err, id, len, tag);
        lo = '0;
        Cpl_Type   = err ? CPL_R_ERR : CPL_R;
        Cpl_ID     = id;
        Cpl_Length = len;
        Cpl_Data   = '0;
        R_Full     = 1'b0;
        @(negedge ACLK);
        check("hdr_grant", 272'({Cpl_Grant, Cpl_Command, R_Push, B_Push}), 272'(4'b1000));
        @(posedge ACLK); #1;
        cyc = 0; c = 0; g = 0; beats = 0; first = -1; cmd_cnt = 0;
        done = 1'b0; aborted = 1'b0;
        while (!done && !aborted && cyc < 2000) begin
            R_Full   = (cyc < 64) ? stall[cyc] : 1'b0;
            Cpl_Type = (err || (cyc < 64 && gap[cyc])) ? NO_CPL : CPL_R;
            Cpl_Data = chunk(tag, c);
            @(negedge ACLK);
            if (Cpl_Command) cmd_cnt++;
            if (R_Push) begin
                if (first < 0) first = cyc;
                beats++;
                if (R_Last) begin
                    done = 1'b1;
                    lo   = R_Data[31:0];
                end
            end
            if (Cpl_Grant) begin
                g++;
                c++;
            end
            @(posedge ACLK); #1;
            cyc++;
            if (rst_after > 0 && beats == rst_after) begin
                ARESETn = 1'b0;
                #1;
                check("rst_cmd", 272'(Cpl_Command), 272'(0));
                check("rst_outs", 272'({R_Push, Cpl_Grant, B_Push}), 272'(0));
                rq.delete();
                @(posedge ACLK); #1;
                ARESETn  = 1'b1;
                Cpl_Type = NO_CPL;
                R_Full   = 1'b0;
                aborted  = 1'b1;
            end
        end
        if (!aborted) begin
            check("burst_done", 272'(done), 272'(1));
            check("first_beat_lat", 272'(first), 272'(0));
            check("beat_count", 272'(beats), 272'(exp_beats));
            check("data_grants", 272'(g), 272'(exp_grants));
            check("cmd_cycles", 272'(cmd_cnt), 272'(exp_cmd));
        end
    endtask

    initial begin
        ARESETn    = 1'b0;
        Cpl_Type   = CPL_B;
        Cpl_Length = 10'd0;
        Cpl_Data   = '0;
        Cpl_ID     = 4'd5;
        B_Full     = 1'b0;
        R_Full     = 1'b0;
        repeat (2) @(negedge ACLK);
        check("reset_outs", 272'({Cpl_Grant, Cpl_Command, B_Push, R_Push, R_Last, B_ID, R_ID, R_Data}), 272'(0));
`ifdef AXI_SLAVE_PUSH_ERR_CNT_EN
        check("reset_errcnt", 272'(Err_Count), 272'(0));
`endif
        @(posedge ACLK); #1;
        ARESETn  = 1'b1;
        Cpl_Type = NO_CPL;
        @(negedge ACLK);
        check("idle_nocpl", 272'({Cpl_Grant, B_Push, R_Push, Cpl_Command}), 272'(0));

        // B response, then a full B buffer for three cycles.
        @(posedge ACLK); #1;
        Cpl_Type = CPL_B;
        Cpl_ID   = 4'd5;
        bq.push_back({4'd5, 2'b00});
        @(negedge ACLK);
        check("b_same_cycle", 272'({B_Push, B_ID, B_Resp, Cpl_Grant}), 272'({1'b1, 4'd5, 2'b00, 1'b1}));
        @(posedge ACLK); #1;
        Cpl_ID = 4'd6;
        B_Full = 1'b1;
        repeat (3) begin
            @(negedge ACLK);
            check("b_full_hold", 272'({B_Push, Cpl_Grant}), 272'(0));
            @(posedge ACLK); #1;
        end
        B_Full = 1'b0;
        bq.push_back({4'd6, 2'b00});
        @(negedge ACLK);
        check("b_after_full", 272'({B_Push, Cpl_Grant}), 272'(2'b11));
        @(posedge ACLK); #1;

        run_r(1'b0, 4'd1, 10'd32, 1, 64'd0, 64'd0, 4, 1, 4, -1, last_lo);
        check("r32_last_dw24", 272'(last_lo), 272'(32'hD101_0018));
        run_r(1'b0, 4'd2, 10'd40, 2, 64'd0, 64'd0, 5, 2, 5, -1, last_lo);
        check("r40_last_dw32", 272'(last_lo), 272'(32'hD202_0020));
        run_r(1'b1, 4'd7, 10'd0, 3, 64'd0, 64'd0, 128, 0, 128, -1, last_lo);
        check("rerr_last_zero", 272'(last_lo), 272'(0));
`ifdef AXI_SLAVE_PUSH_ERR_CNT_EN
        check("err_count", 272'(Err_Count), 272'(1));
`endif
        // R_Full high on the 2nd and 3rd data cycles, then a data-valid gap on a 64 DW read.
        run_r(1'b0, 4'd8, 10'd32, 5, 64'h6, 64'd0, 4, 1, 6, -1, last_lo);
        run_r(1'b0, 4'd10, 10'd64, 6, 64'd0, 64'h8, 8, 2, 9, -1, last_lo);
        check("r64_last_dw56", 272'(last_lo), 272'(32'hD606_0038));

        // Reset after beat 2, then a normal B completion.
        run_r(1'b0, 4'd3, 10'd32, 4, 64'd0, 64'd0, 4, 1, 4, 2, last_lo);
        Cpl_Type = CPL_B;
        Cpl_ID   = 4'd9;
        bq.push_back({4'd9, 2'b00});
        @(negedge ACLK);
        check("b_after_reset", 272'({B_Push, B_ID, Cpl_Grant, Cpl_Command}), 272'({1'b1, 4'd9, 1'b1, 1'b0}));
        @(posedge ACLK); #1;
        Cpl_Type = NO_CPL;
        @(negedge ACLK);
        check("rq_drained", 272'(rq.size()), 272'(0));
        check("bq_drained", 272'(bq.size()), 272'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
